dc_l2_req_responder: RTL and testbench

//  L2-side responder for D-cache tag-bank miss traffic. Accepts REQ_S, REQ_M and displacement (DISP) commands.

---
 rtl/dc_l2_req_responder.sv | 218 +++++++++++++++++++++
 tb/tb_dc_l2_req_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_l2_req_responder.sv
// ---------------------------------------------------------------------------
// dc_l2_req_responder
//
// L2-side responder for D-cache tag-bank miss traffic.  Requests (REQ_S,
// REQ_M, DISP) are queued in arrival order and each one is answered with
// exactly one ack that carries the granted coherence state and the echoed
// request id/address.  A fixed latency of LAT cycles is modelled between
// the controller leaving IDLE and the ack being presented, which is what
// the DC bring-up environment expects from a real L2 pipeline.
//
// Ports
//   clk        : clock
//   reset      : asynchronous, active-high reset
//   req_valid  : request present
//   req_retry  : 1 = request not accepted this cycle (queue full)
//   req_cmd    : CMD_* encoding of the request
//   req_addr   : line address (echoed back unchanged)
//   req_id     : requester tag (echoed back unchanged)
//   ack_valid  : response present
//   ack_retry  : 1 = DC cannot take the response this cycle
//   ack_cmd    : echoed command, or CMD_NACK for an illegal command
//   ack_id     : echoed request id
//   ack_addr   : echoed request address
//   ack_state  : granted state, I=0 S=1 E=2 M=3
//   err        : sticky flag, set when an illegal command is answered
// ---------------------------------------------------------------------------
module dc_l2_req_responder #(
  parameter int          ADDR_BITS = 32,
  parameter int          ID_BITS   = 3,
  parameter int          DEPTH     = 4,
  parameter int          LAT       = 3,
  parameter logic [2:0]  CMD_REQ_S = 3'd1,
  parameter logic [2:0]  CMD_REQ_M = 3'd2,
  parameter logic [2:0]  CMD_DISP  = 3'd3,
  parameter logic [2:0]  CMD_NACK  = 3'd7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_retry,
  input  logic [2:0]           req_cmd,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [ID_BITS-1:0]   req_id,
  output logic                 ack_valid,
  input  logic                 ack_retry,
  output logic [2:0]           ack_cmd,
  output logic [ID_BITS-1:0]   ack_id,
  output logic [ADDR_BITS-1:0] ack_addr,
  output logic [2:0]           ack_state,
  output logic                 err
);

  // Pointer width is exact because DEPTH is a power of two, so the
  // pointers wrap naturally; the occupancy count needs one extra bit
  // to represent the full value DEPTH.
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LAT);

  // Coherence state encodings driven on ack_state (E=2 is never granted).
  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_M = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Request queue storage and bookkeeping.
  logic [2:0]           r_fifoCmd  [DEPTH];
  logic [ADDR_BITS-1:0] r_fifoAddr [DEPTH];
  logic [ID_BITS-1:0]   r_fifoId   [DEPTH];
  logic [PTR_BITS-1:0]  r_wrPtr;
  logic [PTR_BITS-1:0]  r_rdPtr;
  logic [CNT_BITS-1:0]  r_count;

  // Response controller state and registered ack outputs.
  state_t               r_state;
  logic [3:0]           r_latCnt;
  logic                 r_ackValid;
  logic [2:0]           r_ackCmd;
  logic [ID_BITS-1:0]   r_ackId;
  logic [ADDR_BITS-1:0] r_ackAddr;
  logic [2:0]           r_ackState;
  logic                 r_err;

  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_headCmd;
  logic [2:0]           w_grantCmd;
  logic [2:0]           w_grantState;
  logic                 w_illegal;

  // Retry is purely a function of the registered occupancy: a pop in the
  // same cycle does not open a slot for a push (no bypass path).
  assign req_retry = (r_count == FULL_COUNT);
  assign w_push    = req_valid & ~req_retry;

  // The head leaves the queue only when the DC takes the ack.
  assign w_pop     = (r_state == S_RESP) & r_ackValid & ~ack_retry;

  assign w_headCmd = r_fifoCmd[r_rdPtr];

  // Queue payload is written on every accepted request.  The storage does
  // not need a reset because the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoCmd[r_wrPtr]  <= req_cmd;
      r_fifoAddr[r_wrPtr] <= req_addr;
      r_fifoId[r_wrPtr]   <= req_id;
    end
  end

  // Pointers and occupancy.  A simultaneous push and pop leaves the count
  // unchanged while both pointers advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Grant decode for the head entry.  Anything that is not one of the
  // three known commands is answered with a NACK and an Invalid grant.
  always_comb begin
    w_grantCmd   = CMD_NACK;
    w_grantState = ST_I;
    w_illegal    = 1'b1;
    if (w_headCmd == CMD_REQ_S) begin
      w_grantCmd   = CMD_REQ_S;
      w_grantState = ST_S;
      w_illegal    = 1'b0;
    end else if (w_headCmd == CMD_REQ_M) begin
      w_grantCmd   = CMD_REQ_M;
      w_grantState = ST_M;
      w_illegal    = 1'b0;
    end else if (w_headCmd == CMD_DISP) begin
      w_grantCmd   = CMD_DISP;
      w_grantState = ST_I;
      w_illegal    = 1'b0;
    end
  end

  // Response controller.  IDLE waits for a queued request and loads the
  // latency counter; WAIT counts down and, on the cycle the counter reads
  // 1, captures the head into the ack registers so the ack appears exactly
  // LAT cycles after leaving IDLE; RESP holds the ack stable until the DC
  // accepts it, then returns to IDLE so the next request starts afresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_latCnt   <= '0;
      r_ackValid <= 1'b0;
      r_ackCmd   <= '0;
      r_ackId    <= '0;
      r_ackAddr  <= '0;
      r_ackState <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_latCnt <= LAT_LOAD;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_latCnt <= r_latCnt - 4'd1;
          if (r_latCnt == 4'd1) begin
            r_ackValid <= 1'b1;
            r_ackCmd   <= w_grantCmd;
            r_ackId    <= r_fifoId[r_rdPtr];
            r_ackAddr  <= r_fifoAddr[r_rdPtr];
            r_ackState <= w_grantState;
            if (w_illegal) begin
              r_err <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!ack_retry) begin
            r_ackValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_ackValid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_valid = r_ackValid;
  assign ack_cmd   = r_ackCmd;
  assign ack_id    = r_ackId;
  assign ack_addr  = r_ackAddr;
  assign ack_state = r_ackState;
  assign err       = r_err;

endmodule

// File: tb/tb_dc_l2_req_responder.sv
// ---------------------------------------------------------------------------
// tb_dc_l2_req_responder
//
// Self-checking bench for dc_l2_req_responder.  A transaction-level model
// keeps the accepted requests in a queue; each ack is expected at
// max(accept edge, previous pop edge) + 1 + LAT and must match the head
// entry's grant.  Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_dc_l2_req_responder;

  localparam int ADDR_BITS = 32;
  localparam int ID_BITS   = 3;
  localparam int DEPTH     = 4;
  localparam int LAT       = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_retry;
  logic [2:0]           req_cmd;
  logic [ADDR_BITS-1:0] req_addr;
  logic [ID_BITS-1:0]   req_id;
  logic                 ack_valid;
  logic                 ack_retry;
  logic [2:0]           ack_cmd;
  logic [ID_BITS-1:0]   ack_id;
  logic [ADDR_BITS-1:0] ack_addr;
  logic [2:0]           ack_state;
  logic                 err;

  dc_l2_req_responder #(
    .ADDR_BITS (ADDR_BITS),
    .ID_BITS   (ID_BITS),
    .DEPTH     (DEPTH),
    .LAT       (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_retry (req_retry),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_id    (req_id),
    .ack_valid (ack_valid),
    .ack_retry (ack_retry),
    .ack_cmd   (ack_cmd),
    .ack_id    (ack_id),
    .ack_addr  (ack_addr),
    .ack_state (ack_state),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]           cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [ID_BITS-1:0]   id;
    int                   acc;
  } req_t;

  req_t model[$];
  int   cyc;
  int   lastPop;
  bit   expAckValid;
  bit   errExp;
  bit   lastAccepted;
  int   passCount;
  int   checkCount;
  int   failCount;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected grant from the command rules: S->S, M->M, DISP->I, else NACK/I.
  task automatic grant(input logic [2:0] c, output logic [2:0] gc, output logic [2:0] gs);
    case (c)
      3'd1:    begin gc = 3'd1; gs = 3'd1; end
      3'd2:    begin gc = 3'd2; gs = 3'd3; end
      3'd3:    begin gc = 3'd3; gs = 3'd0; end
      default: begin gc = 3'd7; gs = 3'd0; end
    endcase
  endtask

  // Compare every DUT output against the transaction model for this cycle.
  task automatic checkOutput();
    int         due;
    logic [2:0] gc;
    logic [2:0] gs;
    expAckValid = 1'b0;
    if (model.size() > 0) begin
      due = ((model[0].acc > lastPop) ? model[0].acc : lastPop) + 1 + LAT;
      expAckValid = (cyc >= due);
    end
    check("req_retry", 64'(req_retry), 64'(model.size() == DEPTH));
    check("ack_valid", 64'(ack_valid), 64'(expAckValid));
    if (expAckValid) begin
      grant(model[0].cmd, gc, gs);
      if (gc == 3'd7) errExp = 1'b1;
      check("ack_cmd",   64'(ack_cmd),   64'(gc));
      check("ack_id",    64'(ack_id),    64'(model[0].id));
      check("ack_addr",  64'(ack_addr),  64'(model[0].addr));
      check("ack_state", 64'(ack_state), 64'(gs));
    end
    check("err", 64'(err), 64'(errExp));
  endtask

  // One clock: resolve the handshakes from the model, advance, then check.
  task automatic applyStimulus();
    bit pushNow;
    bit popNow;
    popNow  = expAckValid && !ack_retry;
    pushNow = req_valid && (model.size() < DEPTH);
    @(posedge clk);
    cyc++;
    if (popNow) begin
      void'(model.pop_front());
      lastPop = cyc;
    end
    if (pushNow) model.push_back('{cmd: req_cmd, addr: req_addr, id: req_id, acc: cyc});
    lastAccepted = pushNow;
    #1;
    checkOutput();
  endtask

  task automatic sendReq(input logic [2:0] c, input logic [ADDR_BITS-1:0] a, input logic [ID_BITS-1:0] i);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_id    = i;
    lastAccepted = 1'b0;
    while (!lastAccepted && n < 50) begin
      applyStimulus();
      n++;
    end
    req_valid = 1'b0;
    check("accept", 64'(lastAccepted), 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (model.size() > 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    check("drain", 64'(model.size()), 64'd0);
  endtask

  task automatic waitAck(input string tag, input int budget);
    int n;
    n = 0;
    while (!expAckValid && n < budget) begin
      applyStimulus();
      n++;
    end
    check(tag, 64'(ack_valid), 64'd1);
  endtask

  initial begin
    passCount = 0; checkCount = 0; failCount = 0;
    cyc = 0; lastPop = -100; expAckValid = 1'b0; errExp = 1'b0; lastAccepted = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_id = '0; ack_retry = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack_valid", 64'(ack_valid), 64'd0);
    check("rst_ack_cmd",   64'(ack_cmd),   64'd0);
    check("rst_ack_id",    64'(ack_id),    64'd0);
    check("rst_ack_addr",  64'(ack_addr),  64'd0);
    check("rst_ack_state", 64'(ack_state), 64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_req_retry", 64'(req_retry), 64'd0);
    reset = 1'b0;
    repeat (2) applyStimulus();

    // Single REQ_S with the exact latency and a one-cycle ack
    $display("[TB] single REQ_S");
    sendReq(3'd1, 32'h1000, 3'd5);
    drain(30);
    repeat (3) applyStimulus();

    // Five back-to-back requests against a four-entry queue
    $display("[TB] queue full / retry");
    for (int i = 0; i < 5; i++) sendReq(3'd1 + 3'(i % 3), 32'h4000 + 32'(i * 64), 3'(i));
    drain(100);

    // REQ_M held by ack_retry for six cycles
    $display("[TB] ack_retry hold");
    ack_retry = 1'b1;
    sendReq(3'd2, 32'h8000_0040, 3'd2);
    waitAck("t3_ack_seen", 20);
    repeat (6) applyStimulus();
    ack_retry = 1'b0;
    applyStimulus();
    check("t3_popped", 64'(ack_valid), 64'd0);

    // DISP then REQ_S on the same line
    $display("[TB] DISP then REQ_S");
    sendReq(3'd3, 32'h2040, 3'd6);
    sendReq(3'd1, 32'h2040, 3'd7);
    drain(40);

    // Illegal command sets the sticky error
    $display("[TB] illegal command");
    sendReq(3'd5, 32'h3000, 3'd1);
    drain(20);
    for (int i = 0; i < 10; i++) sendReq(3'(1 + (i % 3)), $urandom, 3'($urandom_range(0, 7)));
    drain(150);
    check("t5_err_sticky", 64'(err), 64'd1);

    // Reset while an ack is pending with more requests queued
    $display("[TB] reset in RESP");
    ack_retry = 1'b1;
    sendReq(3'd1, 32'h5000, 3'd1);
    sendReq(3'd2, 32'h5040, 3'd2);
    sendReq(3'd3, 32'h5080, 3'd3);
    waitAck("t6_ack_seen", 20);
    reset = 1'b1;
    #1;
    check("t6_ack_valid", 64'(ack_valid), 64'd0);
    check("t6_req_retry", 64'(req_retry), 64'd0);
    check("t6_err",       64'(err),       64'd0);
    model.delete();
    errExp = 1'b0; lastPop = -100; expAckValid = 1'b0;
    ack_retry = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      check("t6_in_reset", 64'(ack_valid), 64'd0);
    end
    reset = 1'b0;
    repeat (10) applyStimulus();
    sendReq(3'd2, 32'h6000, 3'd4);
    drain(30);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_cmd   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
      req_addr  = $urandom;
      req_id    = 3'($urandom_range(0, 7));
      ack_retry = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    req_valid = 1'b0;
    ack_retry = 1'b0;
    drain(200);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
